// File: rtl/prt_scaler_lbuf_ctl.sv
// ---------------------------------------------------------------------------
// prt_scaler_lbuf_ctl
//
// Line-buffer controller for the scaler's vertical filter. One simple
// dual-port line RAM is used as a ring of P_LINES line slots. The writer
// fills the slot at wl pixel by pixel; the tap reader addresses stored lines
// relative to rl (tap 0 = oldest stored line) and frees the oldest line with
// a release.
//
// Ports
//   CLK_IN, RST_IN   clock, asynchronous active-low reset
//   CLR_IN           synchronous clear (start of frame), highest priority
//   WR_IN            input pixel valid, WR_EOL_IN marks last pixel of line
//   WR_DAT_IN        input pixel data
//   WR_RDY_OUT       a free line slot exists, writes are accepted
//   RD_IN            tap read request at (RD_TAP_IN, RD_PIX_IN)
//   RD_REL_IN        release the oldest stored line
//   RD_RDY_OUT       at least P_TAPS complete lines are stored
//   RAM_WR_OUT/RAM_WADR_OUT/RAM_WDAT_OUT   RAM write port (1 cycle latency)
//   RAM_RD_OUT/RAM_RADR_OUT                RAM read port (1 cycle latency)
//   LINES_OUT        number of complete lines stored
//   LEN_OUT          pixel count of the last committed line
//   OVF_OUT          sticky: a write was dropped
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module prt_scaler_lbuf_ctl #(
  parameter int P_LINES     = 4,
  parameter int P_LINE_ADR  = 11,
  parameter int P_TAPS      = 2,
  parameter int P_DAT_WIDTH = 48,
  localparam int L          = $clog2(P_LINES)
) (
  input  logic                      CLK_IN,
  input  logic                      RST_IN,
  input  logic                      CLR_IN,
  input  logic                      WR_IN,
  input  logic                      WR_EOL_IN,
  input  logic [P_DAT_WIDTH-1:0]    WR_DAT_IN,
  output logic                      WR_RDY_OUT,
  input  logic                      RD_IN,
  input  logic [L-1:0]              RD_TAP_IN,
  input  logic [P_LINE_ADR-1:0]     RD_PIX_IN,
  input  logic                      RD_REL_IN,
  output logic                      RD_RDY_OUT,
  output logic                      RAM_WR_OUT,
  output logic [L+P_LINE_ADR-1:0]   RAM_WADR_OUT,
  output logic [P_DAT_WIDTH-1:0]    RAM_WDAT_OUT,
  output logic                      RAM_RD_OUT,
  output logic [L+P_LINE_ADR-1:0]   RAM_RADR_OUT,
  output logic [L:0]                LINES_OUT,
  output logic [P_LINE_ADR:0]       LEN_OUT,
  output logic                      OVF_OUT
);

  localparam int W_ADR = L + P_LINE_ADR;

  localparam logic [L:0]          C_LINES   = (L+1)'(P_LINES);
  localparam logic [L:0]          C_TAPS    = (L+1)'(P_TAPS);
  localparam logic [L-1:0]        C_PTR_ONE = L'(1);
  localparam logic [L:0]          C_CNT_ONE = (L+1)'(1);
  localparam logic [P_LINE_ADR:0] C_PC_ONE  = (P_LINE_ADR+1)'(1);

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_LINE = 1'b1
  } wr_state_e;

  // Control state
  wr_state_e           state_q, state_d;
  logic [L-1:0]        wl_q, wl_d;
  logic [L-1:0]        rl_q, rl_d;
  logic [P_LINE_ADR:0] pc_q, pc_d;
  logic [L:0]          cnt_q, cnt_d;
  logic [P_LINE_ADR:0] len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                wr_rdy_q, wr_rdy_d;
  logic                rd_rdy_q, rd_rdy_d;

  // RAM port registers
  logic                   ram_wr_q, ram_wr_d;
  logic [W_ADR-1:0]       wadr_q, wadr_d;
  logic [P_DAT_WIDTH-1:0] wdat_q, wdat_d;
  logic                   ram_rd_q, ram_rd_d;
  logic [W_ADR-1:0]       radr_q, radr_d;

  // Per-cycle event strobes
  logic wr_acc_s;
  logic commit_s;
  logic rel_s;
  logic rd_acc_s;
  logic pc_full_s;

  // Event decode, pointer/count update and writer FSM next state
  always_comb begin
    state_d   = state_q;
    wl_d      = wl_q;
    rl_d      = rl_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    wr_acc_s  = 1'b0;
    commit_s  = 1'b0;
    rel_s     = 1'b0;
    rd_acc_s  = 1'b0;
    // pc has one extra bit; its MSB set means the line already holds
    // 2**P_LINE_ADR pixels and any further pixel must be dropped.
    pc_full_s = pc_q[P_LINE_ADR];

    if (CLR_IN) begin
      state_d = WR_IDLE;
      wl_d    = '0;
      rl_d    = '0;
      pc_d    = '0;
      cnt_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      wr_acc_s = WR_IN & wr_rdy_q & ~pc_full_s;
      // An EOL still closes an overlong line, but is ignored when no slot
      // is free (that line was never being written).
      commit_s = WR_IN & WR_EOL_IN & wr_rdy_q;
      rel_s    = RD_REL_IN & (cnt_q != '0);
      rd_acc_s = RD_IN & rd_rdy_q;

      if (WR_IN && !wr_acc_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end

      if (commit_s) begin
        len_d = wr_acc_s ? (pc_q + C_PC_ONE) : pc_q;
        pc_d  = '0;
        wl_d  = wl_q + C_PTR_ONE;
      end else if (wr_acc_s) begin
        pc_d  = pc_q + C_PC_ONE;
      end else begin
        pc_d  = pc_q;
      end

      if (rel_s) begin
        rl_d = rl_q + C_PTR_ONE;
      end else begin
        rl_d = rl_q;
      end

      // Commit and release together leave the count unchanged.
      case ({commit_s, rel_s})
        2'b10:   cnt_d = cnt_q + C_CNT_ONE;
        2'b01:   cnt_d = cnt_q - C_CNT_ONE;
        default: cnt_d = cnt_q;
      endcase

      case (state_q)
        WR_IDLE: begin
          if (wr_acc_s && !commit_s) begin
            state_d = WR_LINE;
          end else begin
            state_d = WR_IDLE;
          end
        end
        WR_LINE: begin
          if (commit_s) begin
            state_d = WR_IDLE;
          end else begin
            state_d = WR_LINE;
          end
        end
        default: state_d = WR_IDLE;
      endcase
    end

    // Ready flags look at the next count so a commit filling the last slot
    // blocks the writer from the very next cycle on.
    wr_rdy_d = (cnt_d < C_LINES);
    rd_rdy_d = (cnt_d >= C_TAPS);
  end

  // RAM port next values: strobes follow the accepted requests one cycle later
  always_comb begin
    ram_wr_d = wr_acc_s;
    ram_rd_d = rd_acc_s;
    wadr_d   = wadr_q;
    wdat_d   = wdat_q;
    radr_d   = radr_q;
    if (wr_acc_s) begin
      wadr_d = {wl_q, pc_q[P_LINE_ADR-1:0]};
      wdat_d = WR_DAT_IN;
    end else begin
      wadr_d = wadr_q;
      wdat_d = wdat_q;
    end
    // Tap offset wraps naturally in L bits; uses the pre-release rl.
    if (rd_acc_s) begin
      radr_d = {rl_q + RD_TAP_IN, RD_PIX_IN};
    end else begin
      radr_d = radr_q;
    end
  end

  // Control state registers
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q  <= WR_IDLE;
      wl_q     <= '0;
      rl_q     <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      wr_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wl_q     <= wl_d;
      rl_q     <= rl_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      wr_rdy_q <= wr_rdy_d;
      rd_rdy_q <= rd_rdy_d;
    end
  end

  // RAM port registers
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      ram_wr_q <= 1'b0;
      wadr_q   <= '0;
      wdat_q   <= '0;
      ram_rd_q <= 1'b0;
      radr_q   <= '0;
    end else begin
      ram_wr_q <= ram_wr_d;
      wadr_q   <= wadr_d;
      wdat_q   <= wdat_d;
      ram_rd_q <= ram_rd_d;
      radr_q   <= radr_d;
    end
  end

  assign WR_RDY_OUT   = wr_rdy_q;
  assign RD_RDY_OUT   = rd_rdy_q;
  assign RAM_WR_OUT   = ram_wr_q;
  assign RAM_WADR_OUT = wadr_q;
  assign RAM_WDAT_OUT = wdat_q;
  assign RAM_RD_OUT   = ram_rd_q;
  assign RAM_RADR_OUT = radr_q;
  assign LINES_OUT    = cnt_q;
  assign LEN_OUT      = len_q;
  assign OVF_OUT      = ovf_q;

endmodule
